// File: rtl/pixel_sink_fb_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_sink_fb_if
// Description : Frame-buffer write port. One word is written when fb_we and
//               fb_ready are both high on a rising clock edge.
//               master : pixel sink side (drives address/data/valid)
//               slave  : frame-buffer RAM side (drives fb_ready)
// Signals     : fb_addr  [ADDR_W]  frame-buffer word address
//               fb_data  [COLOR_W] write data (4:4:4 RGB by default)
//               fb_we    [1]       write valid
//               fb_ready [1]       RAM accepts the write this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_sink_fb_if #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
) ();

  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_we;
  logic               fb_ready;

  modport master (
    output fb_addr,
    output fb_data,
    output fb_we,
    input  fb_ready
  );

  modport slave (
    input  fb_addr,
    input  fb_data,
    input  fb_we,
    output fb_ready
  );

endinterface
`default_nettype wire

// File: rtl/pixel_sink_fb.sv
`default_nettype none
// ============================================================================
// Module      : pixel_sink_fb
// Description : Receiving end of the draw-FSM pixel stream. Clips pixels to
//               the visible screen, buffers them in a small FIFO and commits
//               them to the frame-buffer write port. Also performs a
//               full-screen clear on request; pixels queued at that moment
//               are drawn after the clear completes.
// Ports       : clock        system clock, rising edge
//               reset        synchronous active-high reset
//               inX/inY      pixel coordinates from the draw FSM
//               inColor      pixel colour
//               inWriteEn    pixel valid (no backpressure toward the source)
//               clear_req    one-cycle full-screen clear request
//               clear_color  fill colour, sampled with clear_req
//               fb           frame-buffer write port (master side)
//               busy         any work queued, in flight or pending
//               clear_done   one-cycle pulse after the last clear write
//               overflow     sticky: a pixel was dropped on a full FIFO
//               clip_count   saturating count of clipped pixels
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_sink_fb #(
  parameter int FIFO_DEPTH = 8,    // power of 2, >= 2
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int COLOR_W    = 12,
  parameter int ADDR_W     = 17
) (
  input  wire                clock,
  input  wire                reset,
  input  wire  [8:0]         inX,
  input  wire  [7:0]         inY,
  input  wire  [COLOR_W-1:0] inColor,
  input  wire                inWriteEn,
  input  wire                clear_req,
  input  wire  [COLOR_W-1:0] clear_color,
  pixel_sink_fb_if.master    fb,
  output logic               busy,
  output logic               clear_done,
  output logic               overflow,
  output logic [7:0]         clip_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w   = c_ptr_w + 1;
  localparam int c_entry_w = ADDR_W + COLOR_W;

  localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic                 r_fb_we;
  logic [ADDR_W-1:0]    r_fb_addr;
  logic [COLOR_W-1:0]   r_fb_data;

  logic                 r_clear_pending;
  logic [COLOR_W-1:0]   r_clear_color;
  logic                 r_clear_done;
  logic                 r_overflow;
  logic [7:0]           r_clip_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                 w_clip;
  logic                 w_in_valid;
  logic                 w_push;
  logic                 w_drop_full;
  logic                 w_empty;
  logic                 w_full;
  logic [c_entry_w-1:0] w_head;
  logic [ADDR_W-1:0]    w_y_ext;
  logic [ADDR_W-1:0]    w_x_ext;
  logic [ADDR_W-1:0]    w_pix_addr;
  logic                 w_clear_req_ok;
  logic [COLOR_W-1:0]   w_start_color;

  logic                 w_pop;          // head of FIFO moves to output register
  logic                 w_stop;         // write stream ends, output register freed
  logic                 w_clear_start;  // output register loaded with address 0
  logic                 w_clear_adv;    // accepted clear write, step address
  logic                 w_clear_end;    // last clear address accepted

  // --------------------------------------------------------------------------
  // Input stage: clip, address generation, FIFO push decision
  // --------------------------------------------------------------------------
  assign w_clip     = (int'(inX) >= SCREEN_W) || (int'(inY) >= SCREEN_H);
  assign w_in_valid = inWriteEn && !w_clip;

  assign w_y_ext = ADDR_W'(inY);
  assign w_x_ext = ADDR_W'(inX);

  generate
    if (SCREEN_W == 320) begin : g_addr_shift
      // y*320 = y*256 + y*64: two shifts and an add instead of a multiplier
      assign w_pix_addr = (w_y_ext << 8) + (w_y_ext << 6) + w_x_ext;
    end else begin : g_addr_mul
      assign w_pix_addr = (w_y_ext * ADDR_W'(SCREEN_W)) + w_x_ext;
    end
  endgenerate

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_head  = r_mem[r_rd_ptr];

  // A pop in the same edge frees a slot, so a full FIFO can still take a push.
  assign w_push      = w_in_valid && (!w_full || w_pop);
  assign w_drop_full = w_in_valid && w_full && !w_pop;

  // Requests arriving while a clear is running are ignored outright.
  assign w_clear_req_ok = clear_req && (r_state != S_CLEAR);

  // A request landing on the very edge the clear starts is merged into it,
  // so its colour is the one used.
  assign w_start_color = clear_req ? clear_color : r_clear_color;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_pop         = 1'b0;
    w_stop        = 1'b0;
    w_clear_start = 1'b0;
    w_clear_adv   = 1'b0;
    w_clear_end   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Clear wins over queued pixels; it only starts once the output
        // register no longer holds an unaccepted write.
        if (r_clear_pending && !r_fb_we) begin
          w_clear_start = 1'b1;
          w_next_state  = S_CLEAR;
        end else if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_WRITE;
        end
      end

      S_WRITE: begin
        if (fb.fb_ready) begin
          // Chain straight into the next entry for one write per cycle,
          // unless a clear is waiting to take over.
          if (!w_empty && !r_clear_pending) begin
            w_pop = 1'b1;
          end else begin
            w_stop       = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end

      S_CLEAR: begin
        if (fb.fb_ready) begin
          if (r_fb_addr == c_last_addr) begin
            w_clear_end  = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_clear_adv = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed; validity is tracked by r_count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_pix_addr, inColor};
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_fb_we         <= 1'b0;
      r_fb_addr       <= '0;
      r_fb_data       <= '0;
      r_clear_pending <= 1'b0;
      r_clear_color   <= '0;
      r_clear_done    <= 1'b0;
      r_overflow      <= 1'b0;
      r_clip_count    <= '0;
    end else begin
      // FIFO pointers and occupancy
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end

      // Output register: only changes on a load or an accepted write, so it
      // holds steady while the RAM stalls.
      if (w_pop) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= w_head[c_entry_w-1:COLOR_W];
        r_fb_data <= w_head[COLOR_W-1:0];
      end else if (w_clear_start) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= '0;
        r_fb_data <= w_start_color;
      end else if (w_clear_adv) begin
        r_fb_addr <= r_fb_addr + ADDR_W'(1);
      end else if (w_stop || w_clear_end) begin
        r_fb_we <= 1'b0;
      end

      // Clear request bookkeeping
      if (w_clear_start) begin
        r_clear_pending <= 1'b0;
      end else if (w_clear_req_ok) begin
        r_clear_pending <= 1'b1;
      end
      if (w_clear_req_ok) begin
        r_clear_color <= clear_color;
      end
      r_clear_done <= w_clear_end;

      // Input-stage status
      if (w_drop_full) begin
        r_overflow <= 1'b1;
      end
      if (inWriteEn && w_clip && (r_clip_count != 8'hFF)) begin
        r_clip_count <= r_clip_count + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fb.fb_we   = r_fb_we;
  assign fb.fb_addr = r_fb_addr;
  assign fb.fb_data = r_fb_data;

  assign busy       = !w_empty || r_fb_we || r_clear_pending || (r_state == S_CLEAR);
  assign clear_done = r_clear_done;
  assign overflow   = r_overflow;
  assign clip_count = r_clip_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink_fb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_sink_fb
// Description : Self-checking bench for pixel_sink_fb. Expected frame-buffer
//               writes are queued when stimulus is driven and compared, in
//               order, against every accepted write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_sink_fb;

  localparam int FIFO_DEPTH = 8;
  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int COLOR_W    = 12;
  localparam int ADDR_W     = 17;
  localparam int LAST_ADDR  = SCREEN_W * SCREEN_H - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [8:0]         inX;
  logic [7:0]         inY;
  logic [COLOR_W-1:0] inColor;
  logic               inWriteEn;
  logic               clear_req;
  logic [COLOR_W-1:0] clear_color;
  logic               busy;
  logic               clear_done;
  logic               overflow;
  logic [7:0]         clip_count;

  pixel_sink_fb_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) fb ();

  pixel_sink_fb #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .COLOR_W    (COLOR_W),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .inX         (inX),
    .inY         (inY),
    .inColor     (inColor),
    .inWriteEn   (inWriteEn),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .fb          (fb),
    .busy        (busy),
    .clear_done  (clear_done),
    .overflow    (overflow),
    .clip_count  (clip_count)
  );

  always #5 clock = ~clock;

  // Scoreboard of expected {addr, data} writes, oldest first.
  logic [ADDR_W+COLOR_W-1:0] sb [$];
  logic [ADDR_W+COLOR_W-1:0] mon_exp;
  int n_checks     = 0;
  int n_pass       = 0;
  int n_writes     = 0;
  int n_clear_done = 0;
  int last_addr    = -1;

  // Write monitor: sampled on the falling edge, a write counts when it will
  // be accepted on the following rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (clear_done === 1'b1) begin
        n_clear_done++;
        n_checks++;
        if (last_addr !== LAST_ADDR || fb.fb_we !== 1'b0)
          $display("FAIL clear_done_pulse: last_addr=%0d fb_we=%b, want last_addr=%0d fb_we=0",
                   last_addr, fb.fb_we, LAST_ADDR);
        else n_pass++;
      end
      if (fb.fb_we === 1'b1 && fb.fb_ready === 1'b1) begin
        n_writes++;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: write addr=%0d data=%h, want no write",
                   fb.fb_addr, fb.fb_data);
        end else begin
          mon_exp = sb.pop_front();
          if ({fb.fb_addr, fb.fb_data} !== mon_exp)
            $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h",
                     fb.fb_addr, fb.fb_data, mon_exp[ADDR_W+COLOR_W-1:COLOR_W],
                     mon_exp[COLOR_W-1:0]);
          else n_pass++;
        end
        last_addr = int'(fb.fb_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    inWriteEn   = 1'b0;
    clear_req   = 1'b0;
    inX         = '0;
    inY         = '0;
    inColor     = '0;
    clear_color = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    fb.fb_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    n_writes     = 0;
    n_clear_done = 0;
  endtask

  task automatic drive_pixel(input int x, input int y, input logic [COLOR_W-1:0] c,
                             input bit expect_write);
    inX       = 9'(x);
    inY       = 8'(y);
    inColor   = c;
    inWriteEn = 1'b1;
    if (expect_write) sb.push_back({ADDR_W'(y * SCREEN_W + x), c});
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    fb.fb_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (fb.fb_we !== 1'b0) $display("FAIL reset_fb_we: got %b want 0", fb.fb_we); else n_pass++;
    n_checks++; if (fb.fb_addr !== '0) $display("FAIL reset_fb_addr: got %0d want 0", fb.fb_addr); else n_pass++;
    n_checks++; if (fb.fb_data !== '0) $display("FAIL reset_fb_data: got %h want 0", fb.fb_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (clear_done !== 1'b0) $display("FAIL reset_clear_done: got %b want 0", clear_done); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (clip_count !== 8'd0) $display("FAIL reset_clip_count: got %0d want 0", clip_count); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || fb.fb_we !== 1'b0)
      $display("FAIL reset_release_idle: busy=%b fb_we=%b want 0 0", busy, fb.fb_we); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_pixel();
    do_reset();
    drive_pixel(5, 3, 12'hBBB, 1);         // cycle N
    tick();
    inWriteEn = 1'b0;                      // cycle N+1
    n_checks++; if (fb.fb_we !== 1'b0) $display("FAIL single_n1_we: got %b want 0", fb.fb_we); else n_pass++;
    tick();                                // cycle N+2
    n_checks++; if (fb.fb_we !== 1'b1) $display("FAIL single_n2_we: got %b want 1", fb.fb_we); else n_pass++;
    n_checks++; if (fb.fb_addr !== 17'd965 || fb.fb_data !== 12'hBBB)
      $display("FAIL single_n2_word: got addr=%0d data=%h want addr=965 data=bbb", fb.fb_addr, fb.fb_data); else n_pass++;
    tick();                                // cycle N+3
    n_checks++; if (fb.fb_we !== 1'b0) $display("FAIL single_n3_we: got %b want 0", fb.fb_we); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sb.size() != 0 || n_writes != 1)
      $display("FAIL single_count: pending=%0d writes=%0d want 0 1", sb.size(), n_writes); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_clipping();
    do_reset();
    drive_pixel(320, 0, 12'h111, 0);  tick();
    drive_pixel(0, 240, 12'h222, 0);  tick();
    drive_pixel(319, 239, 12'h333, 1); tick();
    inWriteEn = 1'b0;
    drain(20);
    tick();
    tick();
    n_checks++; if (clip_count !== 8'd2) $display("FAIL clip_count: got %0d want 2", clip_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL clip_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (sb.size() != 0 || n_writes != 1)
      $display("FAIL clip_writes: pending=%0d writes=%0d want 0 1", sb.size(), n_writes); else n_pass++;
    // Saturation: 260 more clipped pixels must stop the counter at 255.
    for (int i = 0; i < 260; i++) begin
      drive_pixel(400, 100, 12'h444, 0);
      tick();
    end
    inWriteEn = 1'b0;
    tick();
    n_checks++; if (clip_count !== 8'd255) $display("FAIL clip_saturate: got %0d want 255", clip_count); else n_pass++;
    n_checks++; if (n_writes != 1 || busy !== 1'b0)
      $display("FAIL clip_no_write: writes=%0d busy=%b want 1 0", n_writes, busy); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin      // cycles N..N+5
      drive_pixel(10 + i, 20, 12'(12'h400 + i), 1);
      tick();
    end
    inWriteEn = 1'b0;                      // cycle N+6: writes at N+2..N+5 seen
    n_checks++; if (n_writes != 4) $display("FAIL b2b_rate_mid: got %0d writes want 4", n_writes); else n_pass++;
    tick();
    tick();                                // cycle N+8
    n_checks++; if (n_writes != 6) $display("FAIL b2b_rate_end: got %0d writes want 6", n_writes); else n_pass++;
    n_checks++; if (fb.fb_we !== 1'b0 || sb.size() != 0)
      $display("FAIL b2b_idle: fb_we=%b pending=%0d want 0 0", fb.fb_we, sb.size()); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_overflow();
    do_reset();
    fb.fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // one in the output register + FIFO_DEPTH queued; the tenth is dropped
      drive_pixel(i, 10, 12'(256 + i), i < 9);
      tick();
    end
    inWriteEn = 1'b0;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    n_checks++; if (fb.fb_we !== 1'b1 || fb.fb_addr !== 17'd3200)
      $display("FAIL ovf_head: fb_we=%b addr=%0d want 1 3200", fb.fb_we, fb.fb_addr); else n_pass++;
    repeat (5) tick();
    n_checks++; if (fb.fb_addr !== 17'd3200 || fb.fb_data !== 12'h100)
      $display("FAIL ovf_hold: addr=%0d data=%h want 3200 100", fb.fb_addr, fb.fb_data); else n_pass++;
    // Release the stall while pushing into the full FIFO: the pop frees a slot.
    fb.fb_ready = 1'b1;
    drive_pixel(10, 10, 12'h1AA, 1);
    tick();
    inWriteEn = 1'b0;
    drain(40);
    tick();
    tick();
    n_checks++; if (sb.size() != 0 || n_writes != 10)
      $display("FAIL ovf_drain: pending=%0d writes=%0d want 0 10", sb.size(), n_writes); else n_pass++;
    n_checks++; if (overflow !== 1'b1 || busy !== 1'b0)
      $display("FAIL ovf_sticky: overflow=%b busy=%b want 1 0", overflow, busy); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_clear_pending();
    int qx [3];
    bit tog;
    do_reset();
    fb.fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pixel(2 + i, 5, 12'(12'h210 + i), i == 0);
      if (i > 0) qx[i-1] = 2 + i;
      tick();
    end
    inWriteEn = 1'b0;
    tick();
    clear_req   = 1'b1;
    clear_color = 12'h000;
    tick();
    clear_req = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL clr_busy_pending: got %b want 1", busy); else n_pass++;
    for (int a = 0; a <= LAST_ADDR; a++) sb.push_back({ADDR_W'(a), 12'h000});
    for (int i = 0; i < 3; i++) sb.push_back({ADDR_W'(5 * SCREEN_W + qx[i]), 12'(12'h211 + i)});
    tog = 1'b0;
    for (int i = 0; i < 200000 && sb.size() != 0; i++) begin
      if (i == 1000) drive_pixel(300, 200, 12'hC5C, 1);  // accepted during the clear
      else inWriteEn = 1'b0;
      if (i == 2000) begin                               // must be ignored mid-clear
        clear_req   = 1'b1;
        clear_color = 12'hFFF;
      end else clear_req = 1'b0;
      tog = ~tog;
      fb.fb_ready = (fb.fb_addr < 17'd64 || int'(fb.fb_addr) >= LAST_ADDR - 63) ? tog : 1'b1;
      tick();
    end
    idle_inputs();
    fb.fb_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (sb.size() != 0) $display("FAIL clr_drain: pending=%0d want 0", sb.size()); else n_pass++;
    n_checks++; if (n_clear_done != 1) $display("FAIL clr_done_count: got %0d want 1", n_clear_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clr_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    int saved;
    do_reset();
    fb.fb_ready = 1'b1;
    clear_req   = 1'b1;
    clear_color = 12'h7E1;
    for (int a = 0; a < 20; a++) sb.push_back({ADDR_W'(a), 12'h7E1});
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 200 && n_writes < 20; i++) begin
      if (i < 4) drive_pixel(50 + i, 60, 12'(12'h300 + i), 0);
      else inWriteEn = 1'b0;
      tick();
    end
    inWriteEn = 1'b0;
    n_checks++; if (n_writes != 20) $display("FAIL rstmid_progress: got %0d writes want 20", n_writes); else n_pass++;
    fb.fb_ready = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++; if (fb.fb_we !== 1'b0) $display("FAIL rstmid_we: got %b want 0", fb.fb_we); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    reset = 1'b0;
    fb.fb_ready = 1'b1;
    saved = n_writes;
    repeat (20) tick();
    n_checks++; if (n_writes != saved || fb.fb_we !== 1'b0 || n_clear_done != 0)
      $display("FAIL rstmid_quiet: writes=%0d fb_we=%b done=%0d want %0d 0 0",
               n_writes, fb.fb_we, n_clear_done, saved); else n_pass++;
    drive_pixel(7, 7, 12'h3C3, 1);
    tick();
    inWriteEn = 1'b0;
    drain(20);
    tick();
    tick();
    n_checks++; if (sb.size() != 0 || n_writes != saved + 1)
      $display("FAIL rstmid_new_pixel: pending=%0d writes=%0d want 0 %0d",
               sb.size(), n_writes, saved + 1); else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_pixel();
    test_clipping();
    test_back_to_back();
    test_overflow();
    test_clear_pending();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_sink_fb.md
Name: pixel_sink_fb

Overview:
- Receiving end of the pixel-write stream produced by the draw FSMs (hook, rope, objects). Each stream beat is outX/outY/color/writeEn.
- Clips incoming pixels to the screen, buffers them in a small FIFO, and commits them to the frame-buffer memory port using a valid/ready handshake.
- Also performs a full-screen clear on request.
- Sits between the draw FSMs and the frame-buffer RAM feeding the VGA scan-out.

Parameters:
- FIFO_DEPTH, 8, pixel FIFO entries; must be a power of 2, minimum 2.
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- COLOR_W, 12, colour width (4:4:4 RGB).
- ADDR_W, 17, frame-buffer address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inX  in  9  pixel x from the draw FSM.
- inY  in  8  pixel y from the draw FSM.
- inColor  in  COLOR_W  pixel colour.
- inWriteEn  in  1  pixel valid for this cycle; no backpressure toward the source.
- clear_req  in  1  one-cycle pulse requesting a full-screen clear.
- clear_color  in  COLOR_W  fill colour, sampled in the cycle clear_req is high.
- fb_addr  out  ADDR_W  frame-buffer word address.
- fb_data  out  COLOR_W  frame-buffer write data.
- fb_we  out  1  write valid.
- fb_ready  in  1  memory accepts the write when fb_we && fb_ready.
- busy  out  1  high when the FIFO is non-empty, a write is pending, or a clear is pending or active.
- clear_done  out  1  one-cycle pulse after the last clear write is accepted.
- overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full.
- clip_count  out  8  saturating count of pixels discarded by clipping.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO is emptied; state = S_IDLE.
  - fb_we=0, fb_addr=0, fb_data=0.
  - busy=0, clear_done=0, overflow=0, clip_count=0.
  - Any pending or active clear is abandoned. This applies equally to a reset asserted mid-operation.
- Input stage, evaluated every cycle with inWriteEn=1:
  - Clip: if inX>=SCREEN_W or inY>=SCREEN_H, the pixel is discarded and clip_count increments, saturating at 255.
  - Full: otherwise, if the FIFO is full, the pixel is discarded and overflow is set. overflow is cleared only by reset.
  - Accept: otherwise the pixel is written to the FIFO, stored as {addr, color}.
  - Address: addr = inY*SCREEN_W + inX, computed as (y<<8)+(y<<6)+x for the default width. Use a zero-extended ADDR_W result; maximum is 76799.
  - The input stage keeps accepting pixels during S_CLEAR.
- Output register: fb_we/fb_addr/fb_data are registered outputs and are held stable while fb_we=1 && fb_ready=0.
- State machine:
  - S_IDLE:
    - Clear has priority: if a clear is pending (clear_pending=1) and the output register is free, go to S_CLEAR.
    - Otherwise, if the FIFO is non-empty, pop the head into the output register, set fb_we=1, and go to S_WRITE.
  - S_WRITE:
    - On fb_ready=1 the transfer completes.
    - In the same edge, if the FIFO is non-empty and no clear is pending, pop the next entry; this sustains one write per cycle.
    - Otherwise drop fb_we and return to S_IDLE.
  - S_CLEAR:
    - fb_we=1, fb_data=latched clear colour, fb_addr runs from 0 to SCREEN_W*SCREEN_H-1, advancing only on accepted writes.
    - When address 76799 is accepted: clear_done=1 for one cycle, fb_we=0, go to S_IDLE.
    - The FIFO is not popped in this state.
- clear_req handling:
  - clear_req sets clear_pending and latches clear_color in any state.
  - A clear_req arriving during S_CLEAR is ignored; no restart and no re-latch.
  - An in-flight S_WRITE beat always completes before the clear starts.
  - Pixels still in the FIFO are drained after the clear, so they are drawn over the cleared screen.
- Latency: with the FIFO empty and fb_ready=1, a pixel presented in cycle N appears with fb_we=1 in cycle N+2.
- FIFO boundaries:
  - Full and empty are tracked with a count, or with pointers plus a wrap bit.
  - A simultaneous push and pop while full is a legal push, since the pop frees the slot in the same edge.
  - A simultaneous push and pop while empty is not possible; a pushed entry is visible for popping on the following cycle.
- busy = (FIFO non-empty) | fb_we | clear_pending | (state==S_CLEAR).

Test Plan:
- Single pixel: reset, then inX=5, inY=3, inColor=12'hBBB, inWriteEn=1 for one cycle, fb_ready=1 -> fb_we high for exactly one cycle at N+2 with fb_addr=965, fb_data=12'hBBB; busy falls afterwards.
- Clipping: pixels (320,0), (0,240), (319,239) -> only addr 76799 is written; clip_count=2; overflow=0.
- Backpressure/overflow: fb_ready=0, push 10 valid pixels (FIFO_DEPTH=8) -> overflow=1; fb_addr held constant; after fb_ready=1, exactly 9 writes occur (8 FIFO + 1 output register), in order, with no duplicates.
- Clear with pending pixels: clear_req with clear_color=12'h000 while 3 pixels are queued -> the in-flight write completes, then 76800 writes of 0 at addresses 0..76799, clear_done pulse, then the 3 queued pixels are written.
- Throttled clear: fb_ready toggling 1/0 every cycle during a clear -> addresses are gapless and never skipped; clear_done fires once, after the write to address 76799.
- Reset mid-operation: assert reset during S_CLEAR with 4 pixels queued -> next cycle fb_we=0 and busy=0; no further writes until new input arrives.
